// File: rtl/seq_booth_multiplier.sv
// ---------------------------------------------------------------------------
// seq_booth_multiplier
//
// Radix-4 Booth sequential multiplier. Two NUMBITS-wide operands, each
// independently signed or unsigned per transaction, produce a 2*NUMBITS
// product. Two multiplier bits are retired per cycle.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   num_a      multiplicand
//   num_b      multiplier (Booth-recoded)
//   a_signed   1: num_a is two's complement, 0: unsigned
//   b_signed   1: num_b is two's complement, 0: unsigned
//   valid_src  source presents operands
//   ready_src  block accepts operands this cycle (IDLE, reset released)
//   product    result, held stable while valid_dst is high
//   valid_dst  product is valid
//   ready_dst  destination consumes the product
//   fsm_state  debug view of the FSM: 0 = IDLE, 1 = CALC, 2 = DONE
//
// Handshake: a transfer happens on the rising edge where valid and ready
// are both 1. Operands are only sampled on the accept edge; valid_src is
// ignored outside IDLE and ready_dst is ignored outside DONE. Once raised,
// valid_dst stays high until the transfer edge.
//
// Optional feature (macro SEQ_BOOTH_EARLY_TERM_EN): leave CALC as soon as
// every remaining multiplier bit (including b[-1]) is identical, since all
// remaining Booth digits are then zero. Latency becomes 2..ITER+1.
// Without the macro, latency is fixed at ITER+1 and no extra logic exists.
// ---------------------------------------------------------------------------
module seq_booth_multiplier #(
    parameter int NUMBITS = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUMBITS-1:0]     num_a,
    input  logic [NUMBITS-1:0]     num_b,
    input  logic                   a_signed,
    input  logic                   b_signed,
    input  logic                   valid_src,
    output logic                   ready_src,
    output logic [2*NUMBITS-1:0]   product,
    output logic                   valid_dst,
    input  logic                   ready_dst,
    output logic [1:0]             fsm_state
);

    localparam int PW   = 2 * NUMBITS;
    // Multiplier extension is even so it splits into whole radix-4 digits,
    // and at least one bit wider than the operand so an unsigned value
    // stays positive when read as two's complement.
    localparam int BW   = (NUMBITS % 2 == 0) ? NUMBITS + 2 : NUMBITS + 1;
    localparam int ITER = (NUMBITS + 2) / 2;
    localparam int CW   = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [PW-1:0]   mcand;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   acc_next;
    logic [BW:0]     mplier;        // bit 0 holds b[-1]
    logic [BW:0]     mplier_next;
    logic [CW-1:0]   iter_cnt;
    logic            last_step;

    // Arithmetic shift keeps the vacated top bits equal to the extension
    // bit, so the "all remaining bits identical" test stays meaningful.
    assign mplier_next = {{2{mplier[BW]}}, mplier[BW:2]};

    `ifdef SEQ_BOOTH_EARLY_TERM_EN
    assign last_step = (iter_cnt == CW'(1)) ||
                       (mplier_next == '0) || (mplier_next == '1);
    `else
    assign last_step = (iter_cnt == CW'(1));
    `endif

    // Booth digit applied to the accumulator, modulo 2^PW.
    always_comb begin
        acc_next = acc;
        case (mplier[2:0])
            3'b001, 3'b010: acc_next = acc + mcand;
            3'b011:         acc_next = acc + {mcand[PW-2:0], 1'b0};
            3'b100:         acc_next = acc - {mcand[PW-2:0], 1'b0};
            3'b101, 3'b110: acc_next = acc - mcand;
            default:        acc_next = acc;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (valid_src) state_next = CALC;
            CALC:    if (last_step) state_next = DONE;
            DONE:    if (ready_dst) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM: outputs. ready_src is gated by reset so it reads 0 while the
    // block is held in reset even though the state is already IDLE.
    always_comb begin
        ready_src = (state == IDLE) && reset;
        valid_dst = (state == DONE);
        product   = acc;
        fsm_state = state;
    end

    // Datapath
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            iter_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_src) begin
                        mcand    <= {{NUMBITS{a_signed & num_a[NUMBITS-1]}}, num_a};
                        mplier   <= {{(BW-NUMBITS){b_signed & num_b[NUMBITS-1]}},
                                     num_b, 1'b0};
                        acc      <= '0;
                        iter_cnt <= CW'(ITER);
                    end
                end
                CALC: begin
                    acc      <= acc_next;
                    mcand    <= mcand << 2;
                    mplier   <= mplier_next;
                    iter_cnt <= iter_cnt - CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/seq_booth_multiplier.md
Name: seq_booth_multiplier

Overview:
- Parametrised radix-4 Booth sequential multiplier; next generation of the team's sequential signed multiplier.
- Multiplies two NUMBITS-wide operands. Each operand is independently signed or unsigned, chosen per transaction.
- Retires two multiplier bits per cycle, so latency is roughly halved.
- Valid/ready handshake on both sides. Sits between a source stage and a destination stage in a datapath.

Parameters:
- NUMBITS, 16, operand width; legal range 4..64; odd values allowed.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- num_a  input  NUMBITS  multiplicand.
- num_b  input  NUMBITS  multiplier (Booth-recoded).
- a_signed  input  1  1: num_a is two's complement; 0: num_a is unsigned.
- b_signed  input  1  1: num_b is two's complement; 0: num_b is unsigned.
- valid_src  input  1  source presents operands.
- ready_src  output  1  block accepts operands this cycle.
- product  output  2*NUMBITS  result.
- valid_dst  output  1  product is valid.
- ready_dst  input  1  destination consumes the product.

Behaviour:
- Reset (asynchronous, active-low): state=IDLE, ready_src=0 while reset is low, valid_dst=0, product=0, all internal registers=0. Reset asserted in any state aborts the operation immediately.
- States:
  - IDLE: ready_src=1. valid_src=1 captures num_a, num_b, a_signed, b_signed, clears the accumulator, loads the iteration counter, then goes to CALC.
  - CALC: ready_src=0, valid_dst=0. Runs one Booth step per cycle. After the final step, goes to DONE.
  - DONE: valid_dst=1; product is held stable. When ready_dst=1, goes to IDLE at that edge.
- Handshake:
  - Transfer happens on the rising edge where valid and ready are both 1.
  - Operands need only be valid in the accept cycle; later changes are ignored.
  - valid_src during CALC or DONE is ignored (no capture).
  - ready_dst outside DONE has no effect.
  - valid_dst may not drop until the transfer completes.
- Extension:
  - Multiplicand is extended to 2*NUMBITS: sign-extended if a_signed=1, else zero-extended.
  - Multiplier is extended to W bits: W=NUMBITS+2 if NUMBITS is even, W=NUMBITS+1 if odd. Upper bits are the sign if b_signed=1, else 0. An implicit bit b[-1]=0 is appended.
- Booth step:
  - Take triplet {b[i+1], b[i], b[i-1]}. Digits: 000/111 → 0, 001/010 → +M, 011 → +2M, 100 → -2M, 101/110 → -M.
  - Add the digit to the accumulator, modulo 2^(2*NUMBITS).
  - Shift M left by 2, zero-fill. Shift the multiplier right by 2, keeping the last-shifted-out bit as b[-1].
- Iterations: ITER = floor((NUMBITS+2)/2); 9 for NUMBITS=16.
- Latency: valid_dst rises exactly ITER+1 cycles after the accept edge.
- Throughput: back-to-back ops cost 1 IDLE cycle each. Max rate is one op per ITER+2 cycles (with ready_dst held 1).
- Result interpretation:
  - Signed two's complement if either operand is signed; unsigned otherwise.
  - All mode combinations fit exactly in 2*NUMBITS; no overflow flag.

Optional Feature:
- Macro: SEQ_BOOTH_EARLY_TERM_EN.
- When defined:
  - In CALC, if all remaining multiplier bits plus b[-1] are all 0 or all 1, all remaining digits are 0. The FSM goes to DONE at that edge.
  - The check also applies on the cycle after accept, so operand b=0 reaches DONE after 1 CALC cycle.
  - Latency becomes variable, 2..ITER+1; the result is identical.
- When undefined: fixed latency ITER+1. The termination logic is not synthesised.

Test Plan (NUMBITS=16 unless noted):
- a=0x8000, b=0x8000, both signed → product 0x40000000; valid_dst exactly 10 cycles after accept (macro off).
- a=0xFFFF, b=0xFFFF, both unsigned → 0xFFFE0001. Same operands, both signed → 0x00000001.
- a=0xFFFF (signed, -1), b=0xFFFF (unsigned, 65535) → 0xFFFF0001. Swap the modes → 0xFFFF0001.
- Back-pressure: ready_dst=0 for 5 cycles after valid_dst rises → product and valid_dst stable; ready_src=0 throughout. ready_dst=1 → IDLE next cycle. valid_src pulsed during CALC → no capture.
- reset low for 1 cycle mid-CALC (cycle 4) → valid_dst=0, product=0. Next op, a=7, b=-3 signed → 0xFFFFFFEB.
- Macro on: a=0x1234, b=0x0003 unsigned → 0x0000369C after ≤3 cycles. b=0 → DONE after 1 CALC cycle. NUMBITS=7 random signed/unsigned sweep vs reference model.
